sram_march_tester: RTL

- Bus master client that runs a March-style memory test over a window of SRAM words.
- Sits upstream of biu_master (and, through the bus, of sram_controller), in place of the ROM-driven test master.
- Drives the biu request fields (address, data_out, rnw, en) and consumes busy, data_valid and data_in.
- Reports pass/fail plus the first failing address, expected data and actual data, so a top level can forward them to seg7_controller.

---
 rtl/sram_march_tester.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sram_march_tester.sv
// March-style SRAM tester acting as a bus master ahead of biu_master.
// Sequence: W(P) up, {R(P),W(~P)} up, {R(~P),W(P)} down, R(P) up.
// The first read mismatch is captured and the run stops early.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | waiting for i_start
// W_INIT    | write P to every word, ascending
// M1_RD     | issue read, ascending, expecting P
// M1_WAIT   | wait for read data of M1
// M1_WR     | write ~P, ascending
// M2_RD     | issue read, descending, expecting ~P
// M2_WAIT   | wait for read data of M2
// M2_WR     | write P, descending
// M3_RD     | issue read, ascending, expecting P
// M3_WAIT   | wait for read data of M3
// DONE      | one-cycle o_done pulse, then back to IDLE
module sram_march_tester #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h80000000,
  parameter int                    NUM_WORDS   = 16,
  parameter int                    ADDR_STRIDE = 1,
  parameter logic [DATA_WIDTH-1:0] PATTERN     = 32'h5a5aa5a5
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_biu_address,
  output logic [DATA_WIDTH-1:0] o_biu_data_out,
  output logic                  o_biu_rnw,
  output logic                  o_biu_en,
  input  logic                  i_biu_busy,
  input  logic                  i_biu_data_valid,
  input  logic [DATA_WIDTH-1:0] i_biu_data_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic [DATA_WIDTH-1:0] o_fail_exp,
  output logic [DATA_WIDTH-1:0] o_fail_act
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [DATA_WIDTH-1:0] PAT_P    = PATTERN;
  localparam logic [DATA_WIDTH-1:0] PAT_N    = ~PATTERN;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_INIT  = 4'd1;
  localparam logic [3:0] S_M1_RD   = 4'd2;
  localparam logic [3:0] S_M1_WAIT = 4'd3;
  localparam logic [3:0] S_M1_WR   = 4'd4;
  localparam logic [3:0] S_M2_RD   = 4'd5;
  localparam logic [3:0] S_M2_WAIT = 4'd6;
  localparam logic [3:0] S_M2_WR   = 4'd7;
  localparam logic [3:0] S_M3_RD   = 4'd8;
  localparam logic [3:0] S_M3_WAIT = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  logic [3:0]            r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_pass;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_exp;
  logic [DATA_WIDTH-1:0] r_fail_act;

  logic                  w_issue;
  logic                  w_rnw;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_expect;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_first;
  logic                  w_mismatch;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Per-state request decode: which states issue, read vs write, write data and expected read data.
  always_comb begin
    w_issue  = 1'b0;
    w_rnw    = 1'b0;
    w_wdata  = PAT_P;
    w_expect = PAT_P;
    case (r_state)
      S_W_INIT: w_issue = 1'b1;
      S_M1_RD:  begin w_issue = 1'b1; w_rnw = 1'b1; end
      S_M1_WR:  begin w_issue = 1'b1; w_wdata = PAT_N; end
      S_M2_RD:  begin w_issue = 1'b1; w_rnw = 1'b1; end
      S_M2_WAIT: w_expect = PAT_N;
      S_M2_WR:  w_issue = 1'b1;
      S_M3_RD:  begin w_issue = 1'b1; w_rnw = 1'b1; end
      default:  ;
    endcase
  end

  assign w_accept   = w_issue & ~i_biu_busy;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_first    = (r_idx == '0);
  assign w_mismatch = (i_biu_data_in != w_expect);
  assign w_addr     = BASE_ADDR + ADDR_WIDTH'(r_idx) * STRIDE;

  // March sequencer: index walk, phase changes and first-mismatch capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_act  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state     <= S_W_INIT;
          r_idx       <= '0;
          r_pass      <= 1'b0;
          r_fail_addr <= '0;
          r_fail_exp  <= '0;
          r_fail_act  <= '0;
        end
        S_W_INIT: if (w_accept) begin
          if (w_last) begin
            r_state <= S_M1_RD;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_M1_RD: if (w_accept) r_state <= S_M1_WAIT;
        S_M2_RD: if (w_accept) r_state <= S_M2_WAIT;
        S_M3_RD: if (w_accept) r_state <= S_M3_WAIT;
        S_M1_WAIT, S_M2_WAIT, S_M3_WAIT: if (i_biu_data_valid) begin
          if (w_mismatch) begin
            r_state     <= S_DONE;
            r_pass      <= 1'b0;
            r_fail_addr <= w_addr;
            r_fail_exp  <= w_expect;
            r_fail_act  <= i_biu_data_in;
          end else if (r_state == S_M1_WAIT) begin
            r_state <= S_M1_WR;
          end else if (r_state == S_M2_WAIT) begin
            r_state <= S_M2_WR;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_pass  <= 1'b1;
          end else begin
            r_state <= S_M3_RD;
            r_idx   <= r_idx + IDX_W'(1);
          end
        end
        S_M1_WR: if (w_accept) begin
          if (w_last) begin
            r_state <= S_M2_RD;
            r_idx   <= LAST_IDX;
          end else begin
            r_state <= S_M1_RD;
            r_idx   <= r_idx + IDX_W'(1);
          end
        end
        S_M2_WR: if (w_accept) begin
          if (w_first) begin
            r_state <= S_M3_RD;
            r_idx   <= '0;
          end else begin
            r_state <= S_M2_RD;
            r_idx   <= r_idx - IDX_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_biu_address  = w_addr;
  assign o_biu_data_out = w_wdata;
  assign o_biu_rnw      = w_rnw;
  assign o_biu_en       = w_accept;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_pass         = r_pass;
  assign o_fail_addr    = r_fail_addr;
  assign o_fail_exp     = r_fail_exp;
  assign o_fail_act     = r_fail_act;

endmodule
